// File: rtl/cond_unit_it_pkg.sv
// Shared definitions for the conditional-execution unit: flag bit positions,
// ARM condition encodings and the IT-block state type.
package cond_pkg;

  localparam int NEG = 3;
  localparam int ZER = 2;
  localparam int CAR = 1;
  localparam int OVR = 0;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_t;

endpackage

// File: rtl/cond_unit_it_if.sv
// Bundle between decode/execute (master) and the conditional unit (slave).
interface cond_unit_it_if #(
  parameter int IT_MAX = 4,
  parameter int LEN_W  = $clog2(IT_MAX + 1),
  parameter int CNT_W  = 16
);
  logic              InstrValid;
  logic [3:0]        Cond;
  logic [3:0]        ALUFlags;
  logic [3:0]        FlagW;
  logic              PCS;
  logic              RegW;
  logic              MemW;
  logic              ITStart;
  logic [3:0]        ITCond;
  logic [LEN_W-1:0]  ITLen;
  logic [IT_MAX-1:0] ITThen;
  logic              Flush;
  logic              PCSrc;
  logic              RegWrite;
  logic              MemWrite;
  logic              storedCarry;
  logic              InITBlock;
  logic [CNT_W-1:0]  SquashCount;

  modport master (
    output InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
           ITStart, ITCond, ITLen, ITThen, Flush,
    input  PCSrc, RegWrite, MemWrite, storedCarry, InITBlock, SquashCount
  );

  modport slave (
    input  InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
           ITStart, ITCond, ITLen, ITThen, Flush,
    output PCSrc, RegWrite, MemWrite, storedCarry, InITBlock, SquashCount
  );
endinterface

// File: rtl/cond_unit_it_condcheck.sv
// ARM condition evaluation on {N,Z,C,V}; the reserved 1111 encoding never passes.
module condcheck
  import cond_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_ge;

  // Condition table lookup.
  always_comb begin
    w_n  = i_flags[NEG];
    w_z  = i_flags[ZER];
    w_c  = i_flags[CAR];
    w_v  = i_flags[OVR];
    w_ge = (w_n == w_v);
    case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~(w_c & ~w_z);
      COND_GE: o_cond_ex = w_ge;
      COND_LT: o_cond_ex = ~w_ge;
      COND_GT: o_cond_ex = ~w_z & w_ge;
      COND_LE: o_cond_ex = ~(~w_z & w_ge);
      COND_AL: o_cond_ex = 1'b1;
      COND_NV: o_cond_ex = 1'b0;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_it_flopenr.sv
// Enabled flop with synchronous active-high reset; holds one or more flag bits.
module flopenr #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Flag storage: reset wins, otherwise load on enable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end else begin
      o_q <= o_q;
    end
  end

endmodule

// File: rtl/cond_unit_it.sv
// Conditional-execution unit: NZCV flags, write gating, IT-block tracking and
// a saturating squash counter.
module cond_unit_it
  import cond_pkg::*;
#(
  parameter int IT_MAX = 4,
  parameter int LEN_W  = $clog2(IT_MAX + 1),
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  cond_unit_it_if.slave bus
);

  localparam int SLOT_W = (IT_MAX > 1) ? $clog2(IT_MAX) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(IT_MAX);

  it_state_t         r_state;
  logic              r_in_it;
  logic [3:0]        r_it_cond;
  logic [IT_MAX-1:0] r_it_then;
  logic [SLOT_W-1:0] r_slot;
  logic [LEN_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  r_squash_cnt;

  logic [3:0]        w_flags;
  logic [3:0]        w_eff_cond;
  logic              w_cond_ex;
  logic              w_exec;
  logic              w_pc_src;
  logic              w_squash;
  logic [3:0]        w_flag_en;
  logic [LEN_W-1:0]  w_len_clamped;

  // Inside an IT block the slot polarity picks the base or inverted condition.
  always_comb begin
    if (r_state == IT_ACTIVE) begin
      if (r_it_then[r_slot]) begin
        w_eff_cond = r_it_cond;
      end else begin
        w_eff_cond = r_it_cond ^ 4'b0001;
      end
    end else begin
      w_eff_cond = bus.Cond;
    end
  end

  condcheck u_condcheck (
    .i_cond    (w_eff_cond),
    .i_flags   (w_flags),
    .o_cond_ex (w_cond_ex)
  );

  // The IT instruction itself never writes; reset blocks all writes.
  assign w_exec        = bus.InstrValid & w_cond_ex & ~bus.ITStart & ~reset;
  assign w_pc_src      = bus.PCS & w_exec;
  assign w_squash      = bus.InstrValid & ~bus.ITStart & ~w_cond_ex;
  assign w_flag_en     = bus.FlagW & {4{w_exec}};
  assign w_len_clamped = (bus.ITLen > MAX_LEN) ? MAX_LEN : bus.ITLen;

  assign bus.PCSrc       = w_pc_src;
  assign bus.RegWrite    = bus.RegW & w_exec;
  assign bus.MemWrite    = bus.MemW & w_exec;
  assign bus.storedCarry = w_flags[CAR];
  assign bus.InITBlock   = r_in_it;
  assign bus.SquashCount = r_squash_cnt;

  for (genvar gi = 0; gi < 4; gi++) begin : g_flag
    flopenr #(.WIDTH(1)) u_flag (
      .i_clk   (clk),
      .i_reset (reset),
      .i_en    (w_flag_en[gi]),
      .i_d     (bus.ALUFlags[gi]),
      .o_q     (w_flags[gi])
    );
  end

  // IT-block state machine; flush outranks a new IT instruction and slot use.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IT_IDLE;
      r_in_it     <= 1'b0;
      r_it_cond   <= 4'b0000;
      r_it_then   <= '0;
      r_slot      <= '0;
      r_remaining <= '0;
    end else if (bus.Flush) begin
      r_state     <= IT_IDLE;
      r_in_it     <= 1'b0;
      r_slot      <= '0;
      r_remaining <= '0;
    end else if (bus.InstrValid && bus.ITStart) begin
      if (bus.ITLen != '0) begin
        r_state     <= IT_ACTIVE;
        r_in_it     <= 1'b1;
        r_it_cond   <= bus.ITCond;
        r_it_then   <= bus.ITThen;
        r_slot      <= '0;
        r_remaining <= w_len_clamped;
      end else begin
        r_state <= r_state;
      end
    end else if (r_state == IT_ACTIVE && bus.InstrValid) begin
      if (r_remaining == LEN_W'(1) || w_pc_src) begin
        r_state     <= IT_IDLE;
        r_in_it     <= 1'b0;
        r_slot      <= '0;
        r_remaining <= '0;
      end else begin
        r_slot      <= r_slot + SLOT_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
      end
    end else begin
      r_state <= r_state;
    end
  end

  // Squash counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_squash_cnt <= '0;
    end else if (w_squash && (r_squash_cnt != {CNT_W{1'b1}})) begin
      r_squash_cnt <= r_squash_cnt + CNT_W'(1);
    end else begin
      r_squash_cnt <= r_squash_cnt;
    end
  end

endmodule

// File: tb/tb_cond_unit_it.sv
// Scoreboard bench for cond_unit_it: a 16-bit-counter and a 2-bit-counter
// instance see identical stimulus and are checked against a behavioural model.
module tb_cond_unit_it;

  logic clk;
  logic reset;

  cond_unit_it_if #(.IT_MAX(4), .CNT_W(16)) bus16 ();
  cond_unit_it_if #(.IT_MAX(4), .CNT_W(2))  bus2 ();

  cond_unit_it #(.IT_MAX(4), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  cond_unit_it #(.IT_MAX(4), .CNT_W(2)) u_dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pc;
    logic        rw;
    logic        mw;
    logic        carry;
    logic        init;
    logic [15:0] c16;
    logic [1:0]  c2;
  } exp_t;

  exp_t sb[$];
  int   n_vec     = 0;
  int   n_miscmp  = 0;
  int   vec_idx   = 0;

  logic [3:0] m_flags;
  logic       m_active;
  int         m_slot;
  int         m_rem;
  logic [3:0] m_itcond;
  logic [3:0] m_itthen;
  int         m_cnt16;
  int         m_cnt2;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s vec%0d got=%0h want=%0h", tag, vec_idx, obs, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? ~base : base;
  endfunction

  task automatic model_clear();
    m_flags  = 4'b0000;
    m_active = 1'b0;
    m_slot   = 0;
    m_rem    = 0;
    m_itcond = 4'b0000;
    m_itthen = 4'b0000;
    m_cnt16  = 0;
    m_cnt2   = 0;
  endtask

  task automatic apply(input logic rst, input logic valid, input logic [3:0] cond,
                       input logic [3:0] alu, input logic [3:0] flagw,
                       input logic pcs, input logic regw, input logic memw,
                       input logic itstart, input logic [3:0] itcond,
                       input logic [2:0] itlen, input logic [3:0] itthen,
                       input logic flush);
    logic [3:0] eff;
    logic       cx, ex;
    exp_t       e;
    exp_t       got;
    @(posedge clk);
    #1;
    reset = rst;
    bus16.InstrValid = valid; bus2.InstrValid = valid;
    bus16.Cond       = cond;  bus2.Cond       = cond;
    bus16.ALUFlags   = alu;   bus2.ALUFlags   = alu;
    bus16.FlagW      = flagw; bus2.FlagW      = flagw;
    bus16.PCS        = pcs;   bus2.PCS        = pcs;
    bus16.RegW       = regw;  bus2.RegW       = regw;
    bus16.MemW       = memw;  bus2.MemW       = memw;
    bus16.ITStart    = itstart; bus2.ITStart  = itstart;
    bus16.ITCond     = itcond;  bus2.ITCond   = itcond;
    bus16.ITLen      = itlen;   bus2.ITLen    = itlen;
    bus16.ITThen     = itthen;  bus2.ITThen   = itthen;
    bus16.Flush      = flush;   bus2.Flush    = flush;

    if (m_active) eff = m_itthen[m_slot] ? m_itcond : (m_itcond ^ 4'b0001);
    else          eff = cond;
    cx = cond_ok(eff, m_flags);
    ex = valid & cx & ~itstart & ~rst;
    e.pc    = pcs & ex;
    e.rw    = regw & ex;
    e.mw    = memw & ex;
    e.carry = m_flags[1];
    e.init  = m_active;
    e.c16   = 16'(m_cnt16);
    e.c2    = 2'(m_cnt2);
    sb.push_back(e);

    if (rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < 4; i++) if (flagw[i] & ex) m_flags[i] = alu[i];
      if (valid & ~itstart & ~cx) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (flush) begin
        m_active = 1'b0;
      end else if (valid & itstart) begin
        if (itlen != 3'd0) begin
          m_active = 1'b1;
          m_itcond = itcond;
          m_itthen = itthen;
          m_slot   = 0;
          m_rem    = (int'(itlen) > 4) ? 4 : int'(itlen);
        end
      end else if (m_active & valid) begin
        if (m_rem == 1 || e.pc) begin
          m_active = 1'b0;
        end else begin
          m_slot++;
          m_rem--;
        end
      end
    end

    @(negedge clk);
    got = sb.pop_front();
    check_val("PCSrc",       32'(bus16.PCSrc),       32'(got.pc));
    check_val("RegWrite",    32'(bus16.RegWrite),    32'(got.rw));
    check_val("MemWrite",    32'(bus16.MemWrite),    32'(got.mw));
    check_val("storedCarry", 32'(bus16.storedCarry), 32'(got.carry));
    check_val("InITBlock",   32'(bus16.InITBlock),   32'(got.init));
    check_val("SquashCount", 32'(bus16.SquashCount), 32'(got.c16));
    check_val("SquashSat",   32'(bus2.SquashCount),  32'(got.c2));
    check_val("RegWriteSat", 32'(bus2.RegWrite),     32'(got.rw));
    vec_idx++;
  endtask

  task automatic op(input logic [3:0] cond, input logic [3:0] alu, input logic [3:0] flagw,
                    input logic pcs, input logic regw, input logic memw);
    apply(1'b0, 1'b1, cond, alu, flagw, pcs, regw, memw, 1'b0, 4'h0, 3'd0, 4'h0, 1'b0);
  endtask

  task automatic it_op(input logic [3:0] itcond, input logic [2:0] len, input logic [3:0] then_bits);
    apply(1'b0, 1'b1, 4'hE, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, itcond, len, then_bits, 1'b0);
  endtask

  task automatic bubble();
    apply(1'b0, 1'b0, 4'hE, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 4'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus16.InstrValid = 1'b0; bus2.InstrValid = 1'b0;
    bus16.Cond = 4'h0;  bus2.Cond = 4'h0;
    bus16.ALUFlags = 4'h0; bus2.ALUFlags = 4'h0;
    bus16.FlagW = 4'h0; bus2.FlagW = 4'h0;
    bus16.PCS = 1'b0;   bus2.PCS = 1'b0;
    bus16.RegW = 1'b0;  bus2.RegW = 1'b0;
    bus16.MemW = 1'b0;  bus2.MemW = 1'b0;
    bus16.ITStart = 1'b0; bus2.ITStart = 1'b0;
    bus16.ITCond = 4'h0;  bus2.ITCond = 4'h0;
    bus16.ITLen = 3'd0;   bus2.ITLen = 3'd0;
    bus16.ITThen = 4'h0;  bus2.ITThen = 4'h0;
    bus16.Flush = 1'b0;   bus2.Flush = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);

    // Writes held off during reset.
    apply(1'b1, 1'b1, 4'hE, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 4'h0, 1'b0);

    // Plain conditional: set Z, then EQ passes, NE squashes.
    op(4'hE, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
    op(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    op(4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    bubble();

    // IT EQ, length 3, then/else/then, bubble mid-block.
    it_op(4'h0, 3'd3, 4'b0101);
    op(4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    op(4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    bubble();
    op(4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    bubble();

    // Taken branch in slot 0 ends the block.
    it_op(4'h0, 3'd4, 4'b1111);
    op(4'hE, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    op(4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Flush during slot 1; next instruction uses its own condition.
    it_op(4'h0, 3'd4, 4'b1111);
    op(4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 4'h0, 1'b1);
    op(4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    op(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    // AL else slot never runs; then slot does.
    it_op(4'hE, 3'd2, 4'b0010);
    op(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    op(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);

    // Reserved condition outside IT, and zero-length IT.
    op(4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
    it_op(4'h0, 3'd0, 4'b0000);
    op(4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    op(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Carry set via CS path, then clamped over-long IT.
    op(4'hE, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0);
    it_op(4'h2, 3'd7, 4'b1011);
    for (int k = 0; k < 5; k++) op(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Five squashes push the 2-bit counter to saturation.
    for (int k = 0; k < 5; k++) op(4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      apply(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
    end

    // Reset mid-IT block.
    op(4'hE, 4'b0110, 4'b1111, 1'b0, 1'b0, 1'b0);
    op(4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    it_op(4'h0, 3'd4, 4'b1111);
    op(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 4'hE, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 4'h0, 1'b0);
    op(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    bubble();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/cond_unit_it.md
# cond_unit_it

Conditional-execution unit for the pipelined core. It holds the NZCV flag register and evaluates each instruction's condition against the registered flags, then gates the register, memory, PC and flag writes. It also tracks If-Then (IT) blocks of up to `IT_MAX` instructions, where each slot's condition comes from the block state instead of the instruction. A saturating counter records how many instructions were squashed. It sits between decode/execute and the writeback/fetch controls and replaces the single-instruction condition logic.

## Interface
Parameters:
- `IT_MAX`, 4, maximum instructions in one IT block (1..8).
- `LEN_W`, `$clog2(IT_MAX+1)`, width of `ITLen`.
- `CNT_W`, 16, width of `SquashCount`.

Ports:
- `clk` in 1: the block's single clock.
- `reset` in 1: reset, synchronous and active-high.
- `InstrValid` in 1: the current instruction is real (not a bubble).
- `Cond` in 4: the instruction's condition field; ignored inside an IT block.
- `ALUFlags` in 4: NZCV from the ALU, packed `{N,Z,C,V}`.
- `FlagW` in 4: per-flag write request for N, Z, C, V.
- `PCS`, `RegW`, `MemW` in 1 each: raw write requests for PC, register file and memory.
- `ITStart` in 1: the current instruction is an IT instruction.
- `ITCond` in 4: the base condition of the IT block.
- `ITLen` in `LEN_W`: number of instructions the IT block covers.
- `ITThen` in `IT_MAX`: per-slot polarity; bit i=1 runs slot i on `ITCond` ("then"), 0 runs it on the inverted condition ("else").
- `Flush` in 1: pipeline flush; aborts any active IT block.
- `PCSrc`, `RegWrite`, `MemWrite` out 1 each: gated writes.
- `storedCarry` out 1: registered C flag, used by the ALU.
- `InITBlock` out 1: high while the block is in IT_ACTIVE.
- `SquashCount` out `CNT_W`: saturating count of squashed instructions.

## Operation
- **Effective condition:**
  - In IDLE it is `Cond`.
  - In IT_ACTIVE it is `ITCond` for a then slot and `ITCond ^ 4'b0001` for an else slot.
- **Condition evaluation:** `CondEx` follows the standard ARM table (EQ..AL) on the registered flags. Encoding 1111 gives `CondEx=0`, never X. An else slot with `ITCond=AL` therefore never executes.
- **Write gating:**
  - `RegWrite = RegW & CondEx & InstrValid`; `MemWrite` and `PCSrc` are gated the same way.
  - Each flag is written iff `FlagW[i] & CondEx & InstrValid`.
- **IT instruction:** the cycle with `ITStart=1` never writes anything itself and does not consume a slot. `PCSrc`, `RegWrite` and `MemWrite` are forced to 0 in that cycle.
- **State machine (`IT_IDLE`, `IT_ACTIVE`):**
  - IDLE → ACTIVE on `InstrValid & ITStart & ITLen!=0 & ~Flush`. This latches `ITCond` and `ITThen`, loads `remaining = min(ITLen, IT_MAX)` and sets `slot = 0`.
  - In ACTIVE, each valid non-IT instruction consumes one slot: `slot++` and `remaining--`.
  - ACTIVE → IDLE when the consumed slot was the last one (`remaining==1`), when a taken branch occurs (`PCSrc=1`), or on `Flush`.
  - `ITStart` while ACTIVE restarts the block with the new parameters; the current cycle is treated as an IT instruction (no writes, no slot consumed).
  - `ITLen=0` is ignored: the state stays IDLE, and that cycle still has no writes.
  - Bubbles (`InstrValid=0`) consume no slot and cause no transition, except `Flush`.
- **Squash counter:** `SquashCount` increments when `InstrValid & ~ITStart & ~CondEx`, and saturates at all-ones.
- **Reset:** Flags=0000, state IDLE, `slot`/`remaining` = 0, `SquashCount` = 0. `PCSrc`, `RegWrite` and `MemWrite` are forced to 0 while `reset` is high. After reset, `storedCarry=0` and `InITBlock=0`.

## Timing
- Gated write outputs are combinational from the inputs plus registered state, with zero latency.
- Flag updates become visible to `CondEx` and `storedCarry` on the next cycle. There is no same-cycle bypass.
- State, slot and counter update on the rising edge of `clk`. `InITBlock` goes high the cycle after the IT instruction.
- **Simultaneous events:**
  - `Flush` has priority over `ITStart` and over slot consumption.
  - Writes in a flush cycle are still gated only by `CondEx` and `InstrValid`; squashing a flushed instruction is the pipeline's job.
  - `reset` has priority over everything, including mid-block: the block aborts and the counter clears.

## Structure
- Package `cond_pkg` holds: flag indices (`NEG`, `ZER`, `CAR`, `OVR`), condition encodings (`COND_EQ`..`COND_AL`, `COND_NV`), and the `it_state_t` enum.
- Sub-module `condcheck`: combinational map of `Cond` and flags to `CondEx`, with 1111 returning 0.
- Flag bits use `flopenr`.

## Test plan
- **Plain conditional:** reset; ALU result sets Z=1 with `FlagW=0100`; next cycle `Cond=0000`, `RegW=1` → `RegWrite=1`. Then `Cond=0001` → `RegWrite=0` and `SquashCount=1`.
- **IT block:** with Z=1, send `ITStart`, `ITCond=EQ`, `ITLen=3`, `ITThen=0b101`. The three following valid instructions with `RegW=1` give `RegWrite` 1, 0, 1. `InITBlock` is high for exactly those 3 instruction cycles, and a bubble inserted mid-block extends it by one cycle.
- **Taken branch in slot 0:** an IT block with `ITLen=4` where slot 0 has `PCS=1` and its condition passes → `PCSrc=1`, and `InITBlock=0` the next cycle.
- **Flush mid-block:** assert `Flush` during slot 1 → IDLE next cycle, and the next instruction uses its own `Cond`.
- **Saturation and reset:** with `CNT_W=2`, 5 failing instructions → `SquashCount=3`. Assert `reset` mid-IT block → `InITBlock=0`, flags 0000, counter 0, write outputs 0 during reset.
- **Edge cases:** an `ITCond=AL` else slot gives `CondEx=0`. `Cond=1111` outside IT gives no writes. `ITLen=0` leaves the state IDLE.
